// File: rtl/num_renderer.sv
// Binary-to-decimal number renderer: double-dabble conversion followed by a
// valid/ready stream of 8x8 glyph pixels, most-significant digit first.
module num_renderer #(
  parameter int DIGITS        = 3,
  parameter int VALUE_W       = 10,
  parameter bit LEADING_ZEROS = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic [2:0]         num_digits,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix,
  output logic [5:0]         pix_offset,
  output logic [2:0]         digit_idx,
  output logic [1:0]         dbg_state
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam longint unsigned MAX_VAL = 64'(10 ** DIGITS) - 64'd1;
  localparam logic [VALUE_W-1:0] SAT_VAL = VALUE_W'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             r_state, w_state_next;
  logic [VALUE_W-1:0] r_val;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [2:0]         r_num_digits;
  logic [5:0]         r_pix_offset;
  logic [2:0]         r_digit_idx;

  logic               w_sat;
  logic               w_conv_last;
  logic               w_xfer;
  logic               w_last_pix;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [BCD_W-1:0]   w_bcd_next;
  logic [2:0]         w_nd_next;
  logic [2:0]         w_sel;
  logic [3:0]         w_nib;
  logic [63:0]        w_glyph;

  // Row r of a glyph occupies bits [8r+7:8r]; the column is the bit within the byte.
  function automatic logic [63:0] glyph_rom(input logic [3:0] n);
    case (n)
      4'd1:    glyph_rom = 64'h007E181818183818;
      4'd2:    glyph_rom = 64'h007E60300C06663C;
      4'd3:    glyph_rom = 64'h003C66061C06663C;
      4'd4:    glyph_rom = 64'h000C0C7E6C3C1C0C;
      4'd5:    glyph_rom = 64'h003C6606067C607E;
      4'd6:    glyph_rom = 64'h003C66667C60663C;
      4'd7:    glyph_rom = 64'h00181818180C067E;
      4'd8:    glyph_rom = 64'h003C66663C66663C;
      4'd9:    glyph_rom = 64'h003C66063E66663C;
      default: glyph_rom = 64'h003C6666766E663C;
    endcase
  endfunction

  assign w_sat       = (64'(value) > MAX_VAL);
  assign w_conv_last = (r_cnt == CNT_W'(VALUE_W - 1));
  assign w_xfer      = (r_state == EMIT) && pix_ready;
  assign w_last_pix  = (r_pix_offset == 6'd63) && (r_digit_idx == r_num_digits - 3'd1);

  // One double-dabble step: correct nibbles >= 5, then shift in the next value bit.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_val[VALUE_W-1]};
  end

  always_comb begin
    w_nd_next = 3'd1;
    if (LEADING_ZEROS) begin
      w_nd_next = 3'(DIGITS);
    end else begin
      for (int i = 1; i < DIGITS; i++) begin
        if (w_bcd_next[4*i +: 4] != 4'd0) w_nd_next = 3'(i + 1);
      end
    end
  end

  // Leftmost rendered digit is the most significant rendered nibble.
  assign w_sel = r_num_digits - 3'd1 - r_digit_idx;

  always_comb begin
    w_nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_sel == 3'(i)) w_nib = r_bcd[4*i +: 4];
    end
  end

  assign w_glyph = glyph_rom(w_nib);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    pix_valid    = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_next = CONV;
      CONV: begin
        busy = 1'b1;
        if (w_conv_last) w_state_next = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        pix_valid = 1'b1;
        if (w_xfer && w_last_pix) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_val        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_num_digits <= 3'd1;
      r_pix_offset <= 6'd0;
      r_digit_idx  <= 3'd0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_val <= w_sat ? SAT_VAL : value;
          r_ovf <= w_sat;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        CONV: begin
          r_bcd <= w_bcd_next;
          r_val <= r_val << 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_conv_last) begin
            r_num_digits <= w_nd_next;
            r_pix_offset <= 6'd0;
            r_digit_idx  <= 3'd0;
          end
        end
        EMIT: if (w_xfer) begin
          if (r_pix_offset == 6'd63) begin
            r_pix_offset <= 6'd0;
            r_digit_idx  <= w_last_pix ? 3'd0 : r_digit_idx + 3'd1;
          end else begin
            r_pix_offset <= r_pix_offset + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ovf        = r_ovf;
  assign num_digits = r_num_digits;
  assign pix_offset = r_pix_offset;
  assign digit_idx  = r_digit_idx;
  assign pix        = (r_state == EMIT) && w_glyph[r_pix_offset];
  assign dbg_state  = r_state;

endmodule

// File: doc/num_renderer.md
# num_renderer

Parametrised successor to the score digit renderer. It converts an unsigned binary value into up to DIGITS decimal digits, then streams the 8x8 glyph pixels of each rendered digit, most-significant digit first. It sits between the game score register and the VGA draw FSM. A valid/ready pixel stream replaces the old pause input, and a start/busy/done handshake replaces draw_en/ld_en. New capabilities: configurable digit count and value width, optional leading-zero padding, and overflow saturation.

## Interface
- DIGITS, 3: maximum decimal digits rendered (1..6).
- VALUE_W, 10: width of the input value.
- LEADING_ZEROS, 0: 0 suppresses leading zeros (minimum one digit); 1 always renders DIGITS digits.
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- value  in  VALUE_W  number to render; latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last pixel transfers.
- ovf  out  1  latched value was ≥ 10^DIGITS; held until the next accepted start.
- num_digits  out  3  count of digits rendered this frame (1..DIGITS); valid while in EMIT.
- pix_valid  out  1  pixel stream valid.
- pix_ready  in  1  downstream accepts the pixel.
- pix  out  1  glyph bit.
- pix_offset  out  6  bit index in the glyph: row = [5:3], col = [2:0].
- digit_idx  out  3  rendered digit position; 0 is leftmost.

## Operation
- States: IDLE, CONV, EMIT, DONE.
- IDLE:
  - On start=1: latch value, saturating to 10^DIGITS−1 if larger, and set ovf accordingly.
  - Clear the BCD register and go to CONV.
- CONV: double-dabble binary-to-BCD.
  - BCD register is 4*DIGITS wide.
  - Each cycle: add 3 to every nibble ≥ 5, then shift one value bit in, MSB first.
  - Runs exactly VALUE_W cycles, then goes to EMIT.
- Digit count:
  - LEADING_ZEROS=0: num_digits = index of the highest non-zero BCD nibble + 1, minimum 1 (value 0 renders "0").
  - LEADING_ZEROS=1: num_digits = DIGITS.
- EMIT:
  - Output pixels for digit_idx 0..num_digits−1. Each digit is pix_offset 0..63.
  - pix = glyph[nibble][pix_offset], using the team's standard 8x8 digit font ROM (64-bit word per digit 0–9).
  - Nibble for digit_idx d is BCD nibble (num_digits−1−d).
  - Advance only on pix_valid && pix_ready.
  - pix_offset wraps 63→0 with digit_idx+1.
  - After the transfer of offset 63 of the last digit: go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start while not in IDLE is ignored. value changes after acceptance have no effect.
- While pix_valid=1 && pix_ready=0: pix, pix_offset and digit_idx hold stable, and pix_valid stays high.
- Nibbles 10–15 cannot occur; the ROM default renders "0".

## Timing
- Reset: state IDLE.
  - busy, done, ovf, pix_valid and pix are 0.
  - pix_offset, digit_idx and the BCD register are 0.
  - num_digits is 1.
- Reset in any state takes effect at the next edge; a frame in progress is abandoned with no done pulse.
- Count edges from edge 0, the edge that samples start=1 in IDLE:
  - Edges 1..VALUE_W perform the conversion.
  - pix_valid first rises after edge VALUE_W, showing digit 0, offset 0.
- With pix_ready held high, one pixel transfers per cycle. The last transfer is at edge VALUE_W+64*num_digits.
- done is high for the cycle after the last transfer; busy falls in that same cycle. A new start is accepted at the following edge at the earliest.
- pix_valid is never high outside EMIT.

## Test plan
- DIGITS=3, VALUE_W=10, value=7, pix_ready=1:
  - num_digits=1; 64 pixels equal to the "7" glyph.
  - pix_valid rises after edge 10; done high after edge 74; ovf=0.
- value=305: num_digits=3, digit order 3,0,5; 192 transfers; pixels match the font per digit; done after edge 202.
- value=1000 (>999): renders 9,9,9 with ovf=1; a following start with value=0 renders a single "0" and clears ovf.
- LEADING_ZEROS=1, value=42: digits 0,4,2, num_digits=3. LEADING_ZEROS=0, same value: digits 4,2.
- Random pix_ready toggling during value=815:
  - Outputs stay stable while stalled.
  - Exactly 192 transfers in order, no drops or duplicates; done once.
- Pulse start again mid-EMIT (ignored, frame unaffected).
- Assert reset at digit_idx=1, pix_offset=20: next cycle all outputs are at reset values, no done pulse, and a fresh start works normally.
